// File: rtl/ctrlsrc_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : ctrlsrc_sched_if
// Description : Requester/gain bus between test sequencing and ctrlsrc_sched.
// Revision    : 1.0
// ============================================================================
interface ctrlsrc_sched_if #(
  parameter int W = 16,
  parameter int N = 4
);
  localparam int OW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]        req;
  logic [N*W-1:0]      tgt;
  logic [N-1:0]        ack;
  logic signed [W-1:0] gain;
  logic                busy;
  logic [OW-1:0]       owner;

  modport master (output req, tgt, input ack, gain, busy, owner);
  modport slave  (input req, tgt, output ack, gain, busy, owner);
endinterface
`default_nettype wire

// File: rtl/ctrlsrc_sched.sv
`default_nettype none
// ============================================================================
// Module      : ctrlsrc_sched
// Description : Round-robin scheduler slewing one shared controlled-source
//               gain toward each granted requester's target, then acking.
//               Define CTRLSRC_SLEW_EN for stepped slew; otherwise the gain
//               jumps straight to the target.
// Revision    : 1.0
// ============================================================================
module ctrlsrc_sched #(
  parameter int W      = 16,
  parameter int N      = 4,
  parameter int STEP   = 16,
  parameter int DIV    = 4,
  parameter int SETTLE = 2
) (
  input  wire logic      clk,
  input  wire logic      rst,
  ctrlsrc_sched_if.slave bus
);
  localparam int OW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] c_stl_last = SW'(SETTLE - 1);

  if (STEP < 1 || DIV < 1 || SETTLE < 0) begin : g_cfg_check
    $error("ctrlsrc_sched: STEP and DIV must be >= 1, SETTLE >= 0");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RAMP   = 3'd2,
    S_SETTLE = 3'd3,
    S_ACK    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic signed [W-1:0] gain_q, gain_d;
  logic signed [W-1:0] tgt_q, tgt_d;
  logic [N-1:0]        ack_q, ack_d;
  logic                busy_q, busy_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [OW-1:0]       last_q, last_d;
  logic [SW-1:0]       stl_q, stl_d;

  logic                grant_vld;
  logic [OW-1:0]       grant_idx;
  logic signed [W-1:0] tgt_sel;

  // Walk from the farthest candidate to the nearest so the first set bit
  // after last_q is the final assignment.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_q;
    for (int i = N; i >= 1; i--) begin
      if (bus.req[OW'((int'(last_q) + i) % N)]) begin
        grant_vld = 1'b1;
        grant_idx = OW'((int'(last_q) + i) % N);
      end
    end
  end

  always_comb begin
    tgt_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (owner_q == OW'(i)) tgt_sel = bus.tgt[i*W +: W];
    end
  end

`ifdef CTRLSRC_SLEW_EN
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int WP1 = W + 1;
  localparam logic [PW-1:0]         c_div_last = PW'(DIV - 1);
  localparam logic signed [WP1-1:0] c_step     = WP1'(STEP);

  logic [PW-1:0]        pre_q, pre_d;
  logic signed [W:0]    diff;
  logic signed [W-1:0]  gain_step;

  // One extra bit keeps a full-scale span from wrapping.
  always_comb begin
    diff = {tgt_q[W-1], tgt_q} - {gain_q[W-1], gain_q};
    if (diff > c_step)       gain_step = gain_q + W'(STEP);
    else if (diff < -c_step) gain_step = gain_q - W'(STEP);
    else                     gain_step = tgt_q;
  end
`else
  logic ld_q, ld_d;
`endif

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    tgt_d   = tgt_q;
    owner_d = owner_q;
    last_d  = last_q;
    stl_d   = stl_q;
    ack_d   = '0;
`ifdef CTRLSRC_SLEW_EN
    pre_d   = pre_q;
`else
    ld_d    = ld_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          owner_d = grant_idx;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        tgt_d   = tgt_sel;
`ifdef CTRLSRC_SLEW_EN
        pre_d   = '0;
`else
        ld_d    = 1'b0;
`endif
        state_d = S_RAMP;
      end
      S_RAMP: begin
`ifdef CTRLSRC_SLEW_EN
        if (gain_q == tgt_q) begin
          stl_d = '0;
          if (SETTLE == 0) state_d = S_ACK;
          else             state_d = S_SETTLE;
        end else if (pre_q == c_div_last) begin
          gain_d = gain_step;
          pre_d  = '0;
        end else begin
          pre_d = pre_q + 1'b1;
        end
`else
        // Two-cycle ramp regardless of distance: load, then leave.
        if (ld_q) begin
          stl_d = '0;
          if (SETTLE == 0) state_d = S_ACK;
          else             state_d = S_SETTLE;
        end else begin
          gain_d = tgt_q;
          ld_d   = 1'b1;
        end
`endif
      end
      S_SETTLE: begin
        if (stl_q == c_stl_last) state_d = S_ACK;
        else                     stl_d   = stl_q + 1'b1;
      end
      S_ACK: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A withdrawn request abandons the grant with gain frozen where it is.
    if ((state_q == S_LOAD || state_q == S_RAMP || state_q == S_SETTLE) &&
        !bus.req[owner_q]) begin
      state_d = S_IDLE;
      gain_d  = gain_q;
      last_d  = owner_q;
    end

    if (state_d == S_ACK) begin
      for (int i = 0; i < N; i++) ack_d[i] = (owner_q == OW'(i));
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gain_q  <= '0;
      tgt_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      last_q  <= OW'(N - 1);
      stl_q   <= '0;
`ifdef CTRLSRC_SLEW_EN
      pre_q   <= '0;
`else
      ld_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      tgt_q   <= tgt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      stl_q   <= stl_d;
`ifdef CTRLSRC_SLEW_EN
      pre_q   <= pre_d;
`else
      ld_q    <= ld_d;
`endif
    end
  end

  assign bus.ack   = ack_q;
  assign bus.gain  = gain_q;
  assign bus.busy  = busy_q;
  assign bus.owner = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrlsrc_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrlsrc_sched
// Description : Self-checking bench for ctrlsrc_sched: transaction-level
//               model plus directed literal checks and random traffic.
// Revision    : 1.0
// ============================================================================
module tb_ctrlsrc_sched;
  localparam int W = 16, N = 4, STEP = 16, DIV = 4, SETTLE = 2, OW = 2;
`ifdef CTRLSRC_SLEW_EN
  localparam int ACK_POS = 21, ACK_NEG = 17, ABORT_AT = 10, ABORT_GAIN = 32;
`else
  localparam int ACK_POS = 6,  ACK_NEG = 6,  ABORT_AT = 3,  ABORT_GAIN = 100;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctrlsrc_sched_if #(.W(W), .N(N)) bus ();
  ctrlsrc_sched #(.W(W), .N(N), .STEP(STEP), .DIV(DIV), .SETTLE(SETTLE))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int errors = 0, checks = 0, cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (per grant, closed-form timing) ------
  logic signed [W-1:0] e_gain = '0;
  logic [N-1:0]        e_ack  = '0;
  logic                e_busy = 1'b0;
  logic [OW-1:0]       e_owner = '0;
  bit m_valid = 0, m_active = 0;
  int m_last, m_start, m_owner, m_g0, m_tgt, m_ackc;

  function automatic int tgt_of(input int i);
    logic signed [W-1:0] v;
    v = bus.tgt[i*W +: W];
    return int'(v);
  endfunction

  function automatic int absv(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Gain the active grant must show in absolute cycle c (RAMP entry = start+2).
  function automatic int gain_at(input int c);
    int r, d, mag;
    r = m_start + 2;
    d = m_tgt - m_g0;
`ifdef CTRLSRC_SLEW_EN
    if (c < r) return m_g0;
    mag = ((c - r) / DIV) * STEP;
    if (mag > absv(d)) mag = absv(d);
    return (d < 0) ? m_g0 - mag : m_g0 + mag;
`else
    mag = absv(d);
    return (c >= r + 1) ? m_tgt : m_g0 + 0 * mag;
`endif
  endfunction

  initial begin
    int w, p, last_step;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_valid = 1; m_active = 0; m_last = N - 1;
        e_gain = '0; e_ack = '0; e_busy = 1'b0; e_owner = '0;
      end else if (m_valid) begin
        e_ack = '0;
        if (!m_active) begin
          w = -1;
          for (int i = 1; i <= N; i++)
            if (w < 0 && bus.req[(m_last + i) % N]) w = (m_last + i) % N;
          if (w >= 0) begin
            m_active = 1; m_start = cyc - 1; m_owner = w; m_g0 = int'(e_gain);
            e_owner = OW'(w); e_busy = 1'b1;
          end
        end else begin
          p = cyc - 1 - m_start;
          if (p == 1) begin
            m_tgt = tgt_of(m_owner);
`ifdef CTRLSRC_SLEW_EN
            last_step = m_start + 2 + ((absv(m_tgt - m_g0) + STEP - 1) / STEP) * DIV;
`else
            last_step = m_start + 3;
`endif
            m_ackc = last_step + SETTLE + 1;
          end
          // Abort before the ack cycle, or normal end after it: both go idle
          // with the gain left where it is and priority passed on.
          if ((cyc - 1 < m_ackc && !bus.req[m_owner]) || cyc - 1 == m_ackc) begin
            m_active = 0; e_busy = 1'b0; m_last = m_owner;
          end else begin
            e_gain = W'(gain_at(cyc));
            if (cyc == m_ackc) e_ack[m_owner] = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- compare process ---------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid && !rst) begin
        chk("gain",  longint'(bus.gain), longint'(e_gain));
        chk("ack",   bus.ack,   e_ack);
        chk("busy",  bus.busy,  e_busy);
        chk("owner", bus.owner, e_owner);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic do_reset(input logic [N-1:0] req_after);
    rst = 1'b1;
    repeat (3) begin
      bus.req = N'($urandom);
      bus.tgt = {$urandom, $urandom};
      @(negedge clk);
    end
    rst = 1'b0;
    bus.req = req_after;
  endtask

  task automatic check_reset();
    chk("rst_gain",  longint'(bus.gain), 0);
    chk("rst_ack",   bus.ack, 0);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_owner", bus.owner, 0);
  endtask

  task automatic run_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_ack(input int idx, input int bound);
    int n = 0;
    while (!bus.ack[idx] && n < bound) begin @(negedge clk); n++; end
    chk("ack_seen", bus.ack[idx], 1);
  endtask

  task automatic wait_any_ack(input int bound);
    int n = 0;
    while (bus.ack == '0 && n < bound) begin @(negedge clk); n++; end
    chk("ack_any_seen", (bus.ack != '0), 1);
  endtask

  // ---------------- main sequence ------------------------------------------
  initial begin
    int t, n, ackc, r;
    logic [N-1:0] ackv;
    logic [N-1:0] rr_exp [4];
    rr_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    bus.req = '0;
    bus.tgt = '0;

    do_reset('0);
    check_reset();

    // single ramp 0 -> 64 on requester 0
    bus.tgt[0*W +: W] = 16'sd64;
    bus.req = 4'b0001;
    t = cyc;
`ifdef CTRLSRC_SLEW_EN
    run_to(t + 6);  chk("ramp_g1", longint'(bus.gain), 16);
    run_to(t + 10); chk("ramp_g2", longint'(bus.gain), 32);
    run_to(t + 14); chk("ramp_g3", longint'(bus.gain), 48);
    run_to(t + 18); chk("ramp_g4", longint'(bus.gain), 64);
`else
    run_to(t + 3);  chk("jump_g", longint'(bus.gain), 64);
`endif
    for (int c = t + ACK_POS - 2; c <= t + ACK_POS + 1; c++) begin
      run_to(c);
      chk("ramp_ack", bus.ack, (c == t + ACK_POS) ? 1 : 0);
      if (bus.ack[0]) bus.req[0] = 1'b0;
    end

    // negative target, not a multiple of STEP
    do_reset('0);
    check_reset();
    bus.tgt[2*W +: W] = -16'sd40;
    bus.req = 4'b0100;
    t = cyc; n = 0; ackc = -1; ackv = '0;
`ifdef CTRLSRC_SLEW_EN
    run_to(t + 6);  chk("neg_g1", longint'(bus.gain), -16);
    run_to(t + 10); chk("neg_g2", longint'(bus.gain), -32);
    run_to(t + 14); chk("neg_g3", longint'(bus.gain), -40);
`else
    run_to(t + 3);  chk("neg_g", longint'(bus.gain), -40);
`endif
    for (int c = cyc + 1; c <= t + ACK_NEG + 3; c++) begin
      run_to(c);
      if (bus.ack != '0) begin n++; ackc = c; ackv = bus.ack; end
      if (bus.ack[2]) bus.req[2] = 1'b0;
    end
    chk("neg_ack_count", n, 1);
    chk("neg_ack_cycle", ackc, t + ACK_NEG);
    chk("neg_ack_value", ackv, 4'b0100);
    chk("neg_final_gain", longint'(bus.gain), -40);

    // round-robin with 1011 held from reset
    do_reset(4'b1011);
    bus.tgt[0*W +: W] = 16'sd10;
    bus.tgt[1*W +: W] = -16'sd20;
    bus.tgt[3*W +: W] = 16'sd30;
    for (int k = 0; k < 4; k++) begin
      wait_any_ack(200);
      chk("rr_order", bus.ack, rr_exp[k]);
      @(negedge clk);
      chk("rr_width", bus.ack, 0);
    end
    bus.req = '0;

    // abort of requester 1, pending requester 2 served next
    do_reset(4'b0110);
    bus.tgt[1*W +: W] = 16'sd100;
    bus.tgt[2*W +: W] = 16'sd50;
    t = cyc;
    run_to(t + ABORT_AT);
    chk("abort_pre_gain", longint'(bus.gain), ABORT_GAIN);
    bus.req[1] = 1'b0;
    run_to(t + ABORT_AT + 1);
    chk("abort_gain_held", longint'(bus.gain), ABORT_GAIN);
    chk("abort_idle", bus.busy, 0);
    chk("abort_no_ack", bus.ack, 0);
    run_to(t + ABORT_AT + 2);
    chk("abort_next_owner", bus.owner, 2);
    wait_ack(2, 500);
    bus.req[2] = 1'b0;
    @(negedge clk);
    chk("abort_next_gain", longint'(bus.gain), 50);

    // full-scale spans in both directions
    do_reset('0);
    bus.tgt[0*W +: W] = 16'sh7fff;
    bus.req = 4'b0001;
    wait_ack(0, 9000);
    bus.req = '0;
    chk("fs_top", longint'(bus.gain), 32767);
    @(negedge clk);
    bus.tgt[1*W +: W] = 16'sh8000;
    bus.req = 4'b0010;
    wait_ack(1, 17000);
    bus.req = '0;
    chk("fs_bottom", longint'(bus.gain), -32768);

    // random traffic with early withdrawals and late target changes
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (bus.req[i] && bus.ack[i]) bus.req[i] = 1'b0;
        else if (bus.req[i] && $urandom_range(0, 99) == 0) bus.req[i] = 1'b0;
        else if (!bus.req[i] && $urandom_range(0, 7) == 0) begin
          r = int'($urandom_range(0, 600)) - 300;
          bus.tgt[i*W +: W] = r[W-1:0];
          bus.req[i] = 1'b1;
        end else if ($urandom_range(0, 15) == 0) begin
          r = int'($urandom_range(0, 600)) - 300;
          bus.tgt[i*W +: W] = r[W-1:0];
        end
      end
    end

    // reset in the middle of traffic
    do_reset('0);
    check_reset();
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
